// File: rtl/panel_clock_ctrl.sv
// panel_clock_ctrl: SAP front-panel run/step/clear clock-enable controller with status lamps
module panel_clock_ctrl #(
  parameter int SLOW_DIV = 500,
  parameter int FAST_DIV = 5
) (
  input  logic clock,
  input  logic reset,
  input  logic run_rise,
  input  logic step_rise,
  input  logic clear_rise,
  input  logic fast,
  input  logic halt,
  output logic cpu_clken,
  output logic cpu_clr,
  output logic running,
  output logic halted
);
  localparam int CW = $clog2(SLOW_DIV);
  typedef enum logic [1:0] {STOPPED, RUNNING, HALTED} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n, last;
  logic clken_n, clr_n;
  assign last = fast ? CW'(FAST_DIV - 1) : CW'(SLOW_DIV - 1);
  // state, divider and every output are registered; reset clears them without a clock
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= STOPPED;
      cnt       <= '0;
      cpu_clken <= 1'b0;
      cpu_clr   <= 1'b0;
      running   <= 1'b0;
      halted    <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      cpu_clken <= clken_n;
      cpu_clr   <= clr_n;
      running   <= state_n == RUNNING;
      halted    <= state_n == HALTED;
    end
  end
  // next state with priority clear > halt > run > step; halt is masked while cpu_clr is high
  // because the CPU HLT register only clears one cycle after the clear pulse
  always_comb begin
    state_n = state;
    cnt_n   = '0;
    clken_n = 1'b0;
    clr_n   = 1'b0;
    if (clear_rise) begin
      state_n = STOPPED;
      clr_n   = 1'b1;
    end else if (halt && state != HALTED && !cpu_clr) begin
      state_n = HALTED;
    end else if (state == STOPPED) begin
      if (run_rise) state_n = RUNNING;
      else clken_n = step_rise;
    end else if (state == RUNNING) begin
      if (run_rise) state_n = STOPPED;
      else if (cnt >= last) clken_n = 1'b1;
      else cnt_n = cnt + 1'b1;
    end
  end
endmodule
